cargador_programa: RTL and testbench
====================================

# cargador_programa

Upstream program loader for the `rv32i` single-cycle core. It receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into the core's instruction memory through a dedicated write port. It holds the core in reset until a complete frame with a correct checksum has been stored, so the core only ever fetches a fully loaded program.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width; maximum program length is 2^ADDR_W words.

Ports:
- `clk_RV`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reiniciar`  in  1  synchronous restart pulse; returns the loader to LEN0 from any state.
- `byte_in`  in  8  incoming frame byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address being written.
- `imem_data`  out  32  instruction word being written.
- `reset_core`  out  1  active-high reset to `rv32i`.
- `listo`  out  1  program loaded and verified.
- `error`  out  1  frame rejected.

## Operation
- Frame layout: LEN_L, LEN_H (16-bit word count N, little-endian), then 4·N payload bytes with each word sent LSB first, then one CHK byte.
- CHK is the XOR of every preceding byte in the frame, including the length bytes.
- A byte is accepted when `byte_valid && byte_ready` is true.
- States:
  - LEN0: accept LEN_L, then go to LEN1.
  - LEN1: accept LEN_H. If N > 2^ADDR_W, go to ERROR. If N = 0, go to CHK. Otherwise go to DATA.
  - DATA: collect 4 bytes per word. After the 4th byte, write the word at address `word_cnt` and increment `word_cnt`. After word N−1 is written, go to CHK.
  - CHK: compare the accepted byte against the running XOR. On a match go to LISTO; otherwise go to ERROR.
  - LISTO and ERROR are terminal until `reset` or `reiniciar`.
- `byte_ready` is 1 in LEN0, LEN1, DATA and CHK; it is 0 in LISTO and ERROR, and 0 whenever `reiniciar` is 1.
- `reset_core` is 1 in every state except LISTO. `listo` is 1 only in LISTO; `error` is 1 only in ERROR.
- `reiniciar` clears `word_cnt`, the byte index, the XOR accumulator and the flags, and sends the loader to LEN0. If `reiniciar` and an otherwise valid byte arrive in the same cycle, the byte is not accepted (`reiniciar` wins).
- Words already written before an ERROR remain in memory. The core stays in reset, so they are harmless.
- `word_cnt` is ADDR_W+1 bits wide, which lets N = 2^ADDR_W terminate without wrap-around. `imem_addr` is the low ADDR_W bits of `word_cnt`.

## Timing
- Reset values: state LEN0, `byte_ready` 1, `imem_we` 0, `imem_addr` 0, `imem_data` 0, `reset_core` 1, `listo` 0, `error` 0.
- `imem_we`, `imem_addr` and `imem_data` are registered. `imem_we` pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted. `imem_data` holds {b3,b2,b1,b0}.
- The loader accepts at most one byte per cycle. With `byte_valid` held high, throughput is 4 cycles per word.
- The state register updates on the accept edge. `reset_core` falls, and `listo` rises, on the clock edge that accepts a correct CHK byte.
- The last data word's write pulse occurs in the same cycle as the first CHK-state cycle.
- Asserting `reset` mid-frame forces all outputs to their reset values immediately, asynchronously. The loader then resumes at LEN0.

## Structure
- Shared package `cargador_pkg`: state encoding (LEN0, LEN1, DATA, CHK, LISTO, ERROR) and byte-position constants 0–3.
- A single module with no sub-modules. The word assembler is a 24-bit byte shift register plus a 2-bit index.
- Top-level integration: `reset_core` drives `rv32i.reset`, and the `imem_*` signals drive the instruction-memory write port.

## Test plan
- N=2, words 0x00500093 and 0x00A00113, correct CHK → two writes to addresses 0 and 1 with those values; `listo`=1, `reset_core`=0.
- Same frame with the CHK byte XORed with 0x01 → `error`=1, `reset_core` stays 1, `byte_ready`=0.
- N=0 (bytes 0x00, 0x00, CHK 0x00) → no write; `listo`=1.
- N=257 with ADDR_W=8 (LEN_H=0x01, LEN_L=0x01) → ERROR right after LEN_H; no write.
- `byte_valid` toggled randomly during N=3 → same three writes as the unthrottled case, with no duplicated or lost bytes.
- `reiniciar` after 2 payload bytes, then a fresh N=1 frame with word 0xDEADBEEF → single write of 0xDEADBEEF to address 0; `listo`=1.

Source files
------------

// File: rtl/cargador_pkg.sv
// rtl/cargador_pkg.sv - shared state encoding and byte positions for the program loader
package cargador_pkg;

  localparam logic [2:0] ST_LEN0  = 3'd0;
  localparam logic [2:0] ST_LEN1  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CHK   = 3'd3;
  localparam logic [2:0] ST_LISTO = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  localparam logic [1:0] POS_B0 = 2'd0;
  localparam logic [1:0] POS_B1 = 2'd1;
  localparam logic [1:0] POS_B2 = 2'd2;
  localparam logic [1:0] POS_B3 = 2'd3;

  // States in which the loader still consumes frame bytes
  function automatic logic is_loading(input logic [2:0] st);
    return (st == ST_LEN0) || (st == ST_LEN1) || (st == ST_DATA) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/cargador_programa.sv
// rtl/cargador_programa.sv - framed byte-stream program loader feeding rv32i instruction memory
module cargador_programa
  import cargador_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_RV,
  input  logic              reset,
  input  logic              reiniciar,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              reset_core,
  output logic              listo,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [2:0]       state;
  logic [15:0]      len;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       idx;
  logic [23:0]      shreg;
  logic [7:0]       chk_acc;
  logic [15:0]      n_rx;
  logic             accept;

  assign byte_ready = is_loading(state) && !reiniciar;
  assign accept     = byte_valid && byte_ready;
  assign n_rx       = {byte_in, len[7:0]};
  assign cnt_nxt    = word_cnt + 1'b1;

  assign reset_core = (state != ST_LISTO);
  assign listo      = (state == ST_LISTO);
  assign error      = (state == ST_ERROR);

  always_ff @(posedge clk_RV or negedge reset) begin
    if (!reset) begin
      state     <= ST_LEN0;
      len       <= '0;
      word_cnt  <= '0;
      idx       <= POS_B0;
      shreg     <= '0;
      chk_acc   <= '0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
    end else begin
      imem_we <= 1'b0;
      if (reiniciar) begin
        state    <= ST_LEN0;
        len      <= '0;
        word_cnt <= '0;
        idx      <= POS_B0;
        shreg    <= '0;
        chk_acc  <= '0;
      end else if (accept) begin
        // The checksum byte itself is compared, never folded into the running XOR
        if (state != ST_CHK) begin
          chk_acc <= chk_acc ^ byte_in;
        end
        case (state)
          ST_LEN0: begin
            len[7:0] <= byte_in;
            state    <= ST_LEN1;
          end
          ST_LEN1: begin
            len <= n_rx;
            if ({1'b0, n_rx} > MAX_WORDS) begin
              state <= ST_ERROR;
            end else if (n_rx == 16'd0) begin
              state <= ST_CHK;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (idx == POS_B3) begin
              imem_we   <= 1'b1;
              imem_addr <= word_cnt[ADDR_W-1:0];
              imem_data <= {byte_in, shreg};
              word_cnt  <= cnt_nxt;
              idx       <= POS_B0;
              // word_cnt is one bit wider than the address so N = 2^ADDR_W ends cleanly
              if (16'(cnt_nxt) == len) begin
                state <= ST_CHK;
              end
            end else begin
              shreg <= {byte_in, shreg[23:8]};
              idx   <= idx + 2'd1;
            end
          end
          ST_CHK: begin
            state <= (byte_in == chk_acc) ? ST_LISTO : ST_ERROR;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cargador_programa.sv
// tb/tb_cargador_programa.sv - self-checking bench for cargador_programa
module tb_cargador_programa;

  logic        clk_RV = 1'b0;
  logic        reset;
  logic        reiniciar;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        reset_core;
  logic        listo;
  logic        error;

  cargador_programa #(.ADDR_W(8)) dut (
    .clk_RV     (clk_RV),
    .reset      (reset),
    .reiniciar  (reiniciar),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .reset_core (reset_core),
    .listo      (listo),
    .error      (error)
  );

  always #5 clk_RV = ~clk_RV;

  typedef struct {
    int          n;
    bit          bad;
    bit          throttle;
    bit          fixed_words;
    int          exp_writes;
    bit          exp_listo;
    bit          check_tail;
    logic [39:0] exp_tail;
  } vec_t;

  vec_t        tbl [7];
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  frame [$];
  logic [39:0] exp_w [$];
  logic [39:0] got_w [$];
  logic [31:0] wbuf  [0:299];
  int          exp_last;
  bit          exp_listo;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk_RV) begin
    if (reset && imem_we) got_w.push_back({imem_addr, imem_data});
  end

  task automatic build_frame(input int n, input bit bad);
    logic [7:0] x;
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    if (n <= 256) begin
      for (int i = 0; i < n; i++)
        for (int b = 0; b < 4; b++) frame.push_back(8'(wbuf[i] >> (8 * b)));
    end
    x = 8'h00;
    foreach (frame[k]) x = x ^ frame[k];
    frame.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  // Reference: interpret the frame from its byte-level rules
  task automatic build_expect();
    int n;
    logic [7:0] x;
    n = int'({frame[1], frame[0]});
    exp_w.delete();
    if (n > 256) begin
      exp_last  = 1;
      exp_listo = 1'b0;
    end else begin
      for (int i = 0; i < n; i++)
        exp_w.push_back({8'(i), frame[5+4*i], frame[4+4*i], frame[3+4*i], frame[2+4*i]});
      x = 8'h00;
      for (int k = 0; k < 2 + 4 * n; k++) x = x ^ frame[k];
      exp_last  = 2 + 4 * n;
      exp_listo = (frame[exp_last] == x);
    end
  endtask

  task automatic send_frame(input bit throttle, input int stop_at);
    int  k = 0;
    int  limit;
    int  budget;
    bit  hold;
    bit  rdy;
    bit  we_exp;
    limit  = (stop_at < 0) ? frame.size() : stop_at;
    budget = 20 * limit + 50;
    while (k < limit) begin
      @(negedge clk_RV);
      if (k > exp_last) begin
        chk("ready_after_terminal", byte_ready, 1'b0);
        break;
      end
      if (budget == 0) begin
        chk("send_timeout", 1'b1, 1'b0);
        break;
      end
      budget--;
      byte_valid = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_in    = byte_valid ? frame[k] : 8'($urandom);
      hold       = byte_valid;
      rdy        = byte_ready;
      @(posedge clk_RV);
      #1;
      if (hold) begin
        chk("ready_while_loading", rdy, 1'b1);
        we_exp = (k >= 2) && (k < exp_last) && (((k - 2) % 4) == 3);
        chk("we_after_byte", imem_we, we_exp);
        if (we_exp && imem_we) chk("word_written", {imem_addr, imem_data}, exp_w[(k - 2) / 4]);
        if (k == exp_last) begin
          chk("listo_on_edge", listo, exp_listo);
          chk("error_on_edge", error, !exp_listo);
          chk("reset_core_on_edge", reset_core, !exp_listo);
        end
        k++;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic final_check();
    repeat (2) @(negedge clk_RV);
    chk("n_writes", got_w.size(), exp_w.size());
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) chk("write_seq", got_w[i], exp_w[i]);
    chk("final_listo", listo, exp_listo);
    chk("final_error", error, !exp_listo);
    chk("final_reset_core", reset_core, !exp_listo);
    chk("final_ready", byte_ready, 1'b0);
  endtask

  task automatic restart();
    @(negedge clk_RV);
    reiniciar = 1'b1;
    @(posedge clk_RV);
    #1;
    reiniciar = 1'b0;
    @(negedge clk_RV);
    chk("restart_listo", listo, 1'b0);
    chk("restart_error", error, 1'b0);
    chk("restart_reset_core", reset_core, 1'b1);
    chk("restart_ready", byte_ready, 1'b1);
    got_w.delete();
  endtask

  initial begin
    tbl[0] = '{2,   0, 0, 1, 2,   1, 1, {8'd1, 32'h00A00113}};
    tbl[1] = '{2,   1, 0, 1, 2,   0, 1, {8'd1, 32'h00A00113}};
    tbl[2] = '{0,   0, 0, 0, 0,   1, 0, 40'h0};
    tbl[3] = '{257, 0, 0, 0, 0,   0, 0, 40'h0};
    tbl[4] = '{3,   0, 1, 0, 3,   1, 0, 40'h0};
    tbl[5] = '{256, 0, 0, 0, 256, 1, 0, 40'h0};
    tbl[6] = '{1,   1, 1, 0, 1,   0, 0, 40'h0};

    reset      = 1'b0;
    reiniciar  = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(negedge clk_RV);
    chk("rst_ready", byte_ready, 1'b1);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_data", imem_data, 32'h0);
    chk("rst_reset_core", reset_core, 1'b1);
    chk("rst_listo", listo, 1'b0);
    chk("rst_error", error, 1'b0);
    reset = 1'b1;

    for (int t = 0; t < 7; t++) begin
      restart();
      for (int i = 0; i < 300; i++) wbuf[i] = $urandom;
      if (tbl[t].fixed_words) begin
        wbuf[0] = 32'h00500093;
        wbuf[1] = 32'h00A00113;
      end
      build_frame(tbl[t].n, tbl[t].bad);
      build_expect();
      send_frame(tbl[t].throttle, -1);
      final_check();
      chk("tbl_n_writes", got_w.size(), tbl[t].exp_writes);
      chk("tbl_listo", listo, tbl[t].exp_listo);
      chk("tbl_error", error, !tbl[t].exp_listo);
      if (tbl[t].check_tail && got_w.size() > 1) chk("tbl_tail", got_w[1], tbl[t].exp_tail);
    end

    // reiniciar after two payload bytes, colliding with a valid byte
    restart();
    for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
    build_frame(2, 0);
    build_expect();
    send_frame(0, 4);
    @(negedge clk_RV);
    reiniciar  = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    #1;
    chk("ready_during_reiniciar", byte_ready, 1'b0);
    @(posedge clk_RV);
    #1;
    reiniciar  = 1'b0;
    byte_valid = 1'b0;
    chk("reiniciar_listo", listo, 1'b0);
    chk("reiniciar_error", error, 1'b0);
    got_w.delete();
    wbuf[0] = 32'hDEADBEEF;
    build_frame(1, 0);
    build_expect();
    send_frame(0, -1);
    final_check();
    chk("deadbeef_count", got_w.size(), 1);
    if (got_w.size() > 0) chk("deadbeef_word", got_w[0], {8'h00, 32'hDEADBEEF});
    chk("deadbeef_listo", listo, 1'b1);

    // asynchronous reset in the middle of DATA, after one word was written
    restart();
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom | 32'h1;
    build_frame(4, 0);
    build_expect();
    send_frame(0, 8);
    @(negedge clk_RV);
    #2;
    reset = 1'b0;
    #1;
    chk("async_we", imem_we, 1'b0);
    chk("async_addr", imem_addr, 8'h00);
    chk("async_data", imem_data, 32'h0);
    chk("async_ready", byte_ready, 1'b1);
    chk("async_reset_core", reset_core, 1'b1);
    chk("async_listo", listo, 1'b0);
    @(negedge clk_RV);
    reset = 1'b1;
    got_w.delete();
    for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
    build_frame(2, 0);
    build_expect();
    send_frame(0, -1);
    final_check();

    // randomized frames against the reference
    for (int r = 0; r < 8; r++) begin
      restart();
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      build_frame($urandom_range(1, 8), $urandom_range(0, 3) == 0);
      build_expect();
      send_frame($urandom_range(0, 1) == 1, -1);
      final_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
